// File: rtl/rdmap_hdr_pkg.sv
// Shared opcodes, default geometry and header classification for rdmap_hdr_dispatch.
package rdmap_hdr_pkg;

   localparam int unsigned DEF_HDR_W   = 56;
   localparam int unsigned DEF_TID_W   = 8;
   localparam int unsigned DEF_TID_LSB = 48;
   localparam int unsigned DEF_QN_W    = 16;
   localparam int unsigned DEF_QN_LSB  = 0;
   localparam int unsigned DEF_CNT_W   = 3;

   localparam logic [3:0] OP_SEND    = 4'b0000;
   localparam logic [3:0] OP_REQ     = 4'b0011;
   localparam logic [3:0] OP_ACK     = 4'b0111;
   localparam logic [3:0] OP_WR_DONE = 4'b0110;
   localparam logic [3:0] OP_RD_DONE = 4'b0100;

   typedef enum logic [2:0] {
      CLS_SEND,
      CLS_REQ,
      CLS_ACK,
      CLS_WRDONE,
      CLS_RDDONE,
      CLS_UNKNOWN
   } hdr_cls_e;

   // Any nonzero upper nibble marks the header as unknown regardless of the low opcode.
   function automatic hdr_cls_e classify(input logic [7:0] ctrl);
      hdr_cls_e cls;
      cls = CLS_UNKNOWN;
      if (ctrl[7:4] == 4'h0) begin
         unique case (ctrl[3:0])
            OP_SEND:    cls = CLS_SEND;
            OP_REQ:     cls = CLS_REQ;
            OP_ACK:     cls = CLS_ACK;
            OP_WR_DONE: cls = CLS_WRDONE;
            OP_RD_DONE: cls = CLS_RDDONE;
            default:    cls = CLS_UNKNOWN;
         endcase
      end
      return cls;
   endfunction

endpackage

// File: rtl/rdmap_hdr_dispatch_if.sv
// DDP header handshake between the header source (master) and rdmap_hdr_dispatch (slave).
interface rdmap_hdr_dispatch_if #(
   parameter int unsigned HDR_W = 56
);
   logic             hdrValid;
   logic             hdrReady;
   logic [7:0]       hdrControl;
   logic [HDR_W-1:0] hdrHeader;

   modport master (output hdrValid, output hdrControl, output hdrHeader, input hdrReady);
   modport slave  (input hdrValid, input hdrControl, input hdrHeader, output hdrReady);
endinterface

// File: rtl/rdmap_tid_table.sv
// 1R1W per-TID table with a zeroing sweep after reset; read data is registered and
// a same-address read during write returns the previous contents.
module rdmap_tid_table #(
   parameter int unsigned DEPTH_W = 8,
   parameter int unsigned DATA_W  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic [DEPTH_W-1:0] rd_addr,
   output logic [DATA_W-1:0]  rd_data,
   input  logic               wr_en,
   input  logic [DEPTH_W-1:0] wr_addr,
   input  logic [DATA_W-1:0]  wr_data,
   output logic               init_done
);
   localparam int unsigned DEPTH = 1 << DEPTH_W;

   logic [DATA_W-1:0]  mem_q [DEPTH];
   logic [DEPTH_W-1:0] init_cnt_q, init_cnt_d;
   logic               init_done_q, init_done_d;
   logic [DATA_W-1:0]  rd_data_q, rd_data_d;
   logic               mem_we;
   logic [DEPTH_W-1:0] mem_wa;
   logic [DATA_W-1:0]  mem_wd;

   always_comb begin
      init_cnt_d  = init_cnt_q;
      init_done_d = init_done_q;
      if (!init_done_q) begin
         init_cnt_d = init_cnt_q + 1'b1;
         if (init_cnt_q == '1) init_done_d = 1'b1;
      end
      // The sweep owns the write port until it finishes.
      mem_we    = init_done_q ? wr_en   : 1'b1;
      mem_wa    = init_done_q ? wr_addr : init_cnt_q;
      mem_wd    = init_done_q ? wr_data : '0;
      rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_cnt_q  <= '0;
         init_done_q <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         init_cnt_q  <= init_cnt_d;
         init_done_q <= init_done_d;
         rd_data_q   <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
   end

   assign rd_data   = rd_data_q;
   assign init_done = init_done_q;

endmodule

// File: rtl/rdmap_hdr_dispatch.sv
// RDMAP header classifier/dispatcher with per-TID send segment counting and ack queue numbers.
// Optional build macro HDR_STATS_EN adds saturating send/drop counters.
module rdmap_hdr_dispatch
   import rdmap_hdr_pkg::*;
#(
   parameter int unsigned HDR_W   = DEF_HDR_W,
   parameter int unsigned TID_W   = DEF_TID_W,
   parameter int unsigned TID_LSB = DEF_TID_LSB,
   parameter int unsigned QN_W    = DEF_QN_W,
   parameter int unsigned QN_LSB  = DEF_QN_LSB,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic                  clock,
   input  logic                  reset,
   rdmap_hdr_dispatch_if.slave   hdr,
   output logic                  segNumRd,
   output logic [TID_W-1:0]      segNumRdAddr,
   input  logic [CNT_W-1:0]      segNumRdData,
   output logic                  offloadPush,
   output logic [TID_W-1:0]      offloadData,
   input  logic                  offloadAfull,
   output logic                  sendDonePush,
   output logic [TID_W-1:0]      sendDoneData,
   input  logic                  sendDoneAfull,
   output logic                  ackPush,
   output logic [TID_W+QN_W-1:0] ackData,
   input  logic                  ackFull,
   output logic                  wrDonePush,
   output logic [TID_W-1:0]      wrDoneData,
   input  logic                  wrDoneFull,
   output logic                  rdDonePush,
   output logic [TID_W-1:0]      rdDoneData,
   input  logic                  rdDoneFull,
   output logic                  reqValid,
   output logic [HDR_W-1:0]      reqInfo,
   input  logic                  reqReady,
   input  logic                  queueNumRd,
   input  logic [TID_W-1:0]      queueNumRdAddr,
   output logic [QN_W-1:0]       queueNumRdData
`ifdef HDR_STATS_EN
   ,
   output logic [15:0]           statSendCnt,
   output logic [15:0]           statDropCnt
`endif
);

   hdr_cls_e         cls;
   logic [TID_W-1:0] tid;
   logic [QN_W-1:0]  qn;
   logic             cls_ready, init_done, cnt_init_done, qn_init_done;
   logic             accept, send_acc;

   logic             s1_valid_q, s1_valid_d;
   logic [TID_W-1:0] s1_tid_q, s1_tid_d;
   logic             fwd_hit_q, fwd_hit_d;
   logic [CNT_W-1:0] fwd_data_q, fwd_data_d;
   logic [CNT_W-1:0] cnt_rd, cnt_cur, sent, cnt_wr;
   logic             sop, eop;

   assign cls       = classify(hdr.hdrControl);
   assign tid       = hdr.hdrHeader[TID_LSB +: TID_W];
   assign qn        = hdr.hdrHeader[QN_LSB +: QN_W];
   assign init_done = cnt_init_done & qn_init_done;

   always_comb begin
      cls_ready = 1'b1;
      unique case (cls)
         CLS_SEND:   cls_ready = ~offloadAfull & ~sendDoneAfull;
         CLS_ACK:    cls_ready = ~ackFull;
         CLS_WRDONE: cls_ready = ~wrDoneFull;
         CLS_RDDONE: cls_ready = ~rdDoneFull;
         CLS_REQ:    cls_ready = reqReady;
         default:    cls_ready = 1'b1;
      endcase
   end

   assign hdr.hdrReady = init_done & cls_ready;
   assign accept       = hdr.hdrValid & hdr.hdrReady;
   assign send_acc     = accept & (cls == CLS_SEND);

   assign ackPush    = accept & (cls == CLS_ACK);
   assign ackData    = {tid, qn};
   assign wrDonePush = accept & (cls == CLS_WRDONE);
   assign wrDoneData = tid;
   assign rdDonePush = accept & (cls == CLS_RDDONE);
   assign rdDoneData = tid;
   assign reqValid   = hdr.hdrValid & init_done & (cls == CLS_REQ);
   assign reqInfo    = hdr.hdrHeader;

   assign segNumRd     = send_acc;
   assign segNumRdAddr = tid;

   // Stage-1 write of the previous send is not yet visible in the table read, so
   // a same-TID follower takes the written value from the forward register instead.
   always_comb begin
      cnt_cur    = fwd_hit_q ? fwd_data_q : cnt_rd;
      sent       = cnt_cur + CNT_W'(1);
      sop        = (sent == CNT_W'(1));
      eop        = (sent == segNumRdData) || (segNumRdData == '0) || (sent == '0);
      cnt_wr     = eop ? '0 : sent;
      s1_valid_d = send_acc;
      s1_tid_d   = send_acc ? tid : s1_tid_q;
      fwd_hit_d  = send_acc & s1_valid_q & (tid == s1_tid_q);
      fwd_data_d = fwd_hit_d ? cnt_wr : fwd_data_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_tid_q   <= '0;
         fwd_hit_q  <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_tid_q   <= s1_tid_d;
         fwd_hit_q  <= fwd_hit_d;
         fwd_data_q <= fwd_data_d;
      end
   end

   assign offloadPush  = s1_valid_q & sop;
   assign offloadData  = s1_tid_q;
   assign sendDonePush = s1_valid_q & eop;
   assign sendDoneData = s1_tid_q;

   rdmap_tid_table #(.DEPTH_W(TID_W), .DATA_W(CNT_W)) u_cnt_tbl (
      .clk       (clock),
      .rst       (reset),
      .rd_en     (send_acc),
      .rd_addr   (tid),
      .rd_data   (cnt_rd),
      .wr_en     (s1_valid_q),
      .wr_addr   (s1_tid_q),
      .wr_data   (cnt_wr),
      .init_done (cnt_init_done)
   );

   rdmap_tid_table #(.DEPTH_W(TID_W), .DATA_W(QN_W)) u_qn_tbl (
      .clk       (clock),
      .rst       (reset),
      .rd_en     (queueNumRd),
      .rd_addr   (queueNumRdAddr),
      .rd_data   (queueNumRdData),
      .wr_en     (ackPush),
      .wr_addr   (tid),
      .wr_data   (qn),
      .init_done (qn_init_done)
   );

`ifdef HDR_STATS_EN
   logic [15:0] stat_send_q, stat_send_d;
   logic [15:0] stat_drop_q, stat_drop_d;

   always_comb begin
      stat_send_d = stat_send_q;
      stat_drop_d = stat_drop_q;
      if (send_acc && stat_send_q != '1) stat_send_d = stat_send_q + 16'd1;
      if (accept && cls == CLS_UNKNOWN && stat_drop_q != '1) stat_drop_d = stat_drop_q + 16'd1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_send_q <= '0;
         stat_drop_q <= '0;
      end else begin
         stat_send_q <= stat_send_d;
         stat_drop_q <= stat_drop_d;
      end
   end

   assign statSendCnt = stat_send_q;
   assign statDropCnt = stat_drop_q;
`endif

endmodule

// File: tb/tb_rdmap_hdr_dispatch.sv
// Scoreboard bench for rdmap_hdr_dispatch: per-output expectation queues tagged with the
// cycle each push must appear in; honours HDR_STATS_EN for the statistics ports.
module tb_rdmap_hdr_dispatch;

   typedef struct {
      logic [55:0] data;
      int          cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   rdmap_hdr_dispatch_if #(.HDR_W(56)) hif ();

   logic        segNumRd;
   logic [7:0]  segNumRdAddr;
   logic [2:0]  segNumRdData;
   logic        offloadPush, sendDonePush, ackPush, wrDonePush, rdDonePush, reqValid;
   logic [7:0]  offloadData, sendDoneData, wrDoneData, rdDoneData;
   logic [23:0] ackData;
   logic [55:0] reqInfo;
   logic        offloadAfull, sendDoneAfull, ackFull, wrDoneFull, rdDoneFull, reqReady;
   logic        queueNumRd;
   logic [7:0]  queueNumRdAddr;
   logic [15:0] queueNumRdData;
`ifdef HDR_STATS_EN
   logic [15:0] statSendCnt, statDropCnt;
`endif

   rdmap_hdr_dispatch #(
      .HDR_W(56), .TID_W(8), .TID_LSB(48), .QN_W(16), .QN_LSB(0), .CNT_W(3)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .hdr            (hif.slave),
      .segNumRd       (segNumRd),
      .segNumRdAddr   (segNumRdAddr),
      .segNumRdData   (segNumRdData),
      .offloadPush    (offloadPush),
      .offloadData    (offloadData),
      .offloadAfull   (offloadAfull),
      .sendDonePush   (sendDonePush),
      .sendDoneData   (sendDoneData),
      .sendDoneAfull  (sendDoneAfull),
      .ackPush        (ackPush),
      .ackData        (ackData),
      .ackFull        (ackFull),
      .wrDonePush     (wrDonePush),
      .wrDoneData     (wrDoneData),
      .wrDoneFull     (wrDoneFull),
      .rdDonePush     (rdDonePush),
      .rdDoneData     (rdDoneData),
      .rdDoneFull     (rdDoneFull),
      .reqValid       (reqValid),
      .reqInfo        (reqInfo),
      .reqReady       (reqReady),
      .queueNumRd     (queueNumRd),
      .queueNumRdAddr (queueNumRdAddr),
      .queueNumRdData (queueNumRdData)
`ifdef HDR_STATS_EN
      ,
      .statSendCnt    (statSendCnt),
      .statDropCnt    (statDropCnt)
`endif
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int n_send = 0;
   int n_drop = 0;

   // 0 offload, 1 sendDone, 2 ack, 3 wrDone, 4 rdDone, 5 req
   exp_t  exp_q [6][$];
   string nm [6] = '{"offload", "send_done", "ack", "wr_done", "rd_done", "req"};
   logic [2:0] cnt_m [256];
   logic [2:0] tot_m [256];

   always @(posedge clock) cyc <= cyc + 1;

   // External segment-total table: 1-cycle read latency.
   always @(posedge clock) if (segNumRd === 1'b1) segNumRdData <= tot_m[segNumRdAddr];

   logic [5:0]  pv;
   logic [55:0] dv [6];
   exp_t        me;
   always @(negedge clock) begin
      #2;
      pv    = {reqValid & reqReady, rdDonePush, wrDonePush, ackPush, sendDonePush, offloadPush};
      dv[0] = 56'(offloadData);
      dv[1] = 56'(sendDoneData);
      dv[2] = 56'(ackData);
      dv[3] = 56'(wrDoneData);
      dv[4] = 56'(rdDoneData);
      dv[5] = reqInfo;
      for (int k = 0; k < 6; k++) begin
         if (pv[k] === 1'b1) begin
            checks++;
            if (exp_q[k].size() == 0) begin
               errors++;
               $display("FAIL %s unexpected push data=%h cyc=%0d", nm[k], dv[k], cyc);
            end else begin
               me = exp_q[k].pop_front();
               if (dv[k] !== me.data || cyc !== me.cyc) begin
                  errors++;
                  $display("FAIL %s got data=%h cyc=%0d expected data=%h cyc=%0d",
                           nm[k], dv[k], cyc, me.data, me.cyc);
               end
            end
         end
      end
   end

   task automatic expect_hdr(input logic [7:0] ctrl, input logic [55:0] h, input int c);
      logic [7:0] tid;
      logic [2:0] s;
      exp_t e;
      tid = h[55:48];
      e.cyc = c;
      e.data = 56'(tid);
      if (ctrl[7:4] != 4'h0) begin
         n_drop++;
         return;
      end
      case (ctrl[3:0])
         4'h0: begin
            n_send++;
            s = cnt_m[tid] + 3'd1;
            e.cyc = c + 1;
            if (s == 3'd1) exp_q[0].push_back(e);
            if (s == tot_m[tid] || tot_m[tid] == 3'd0 || s == 3'd0) begin
               exp_q[1].push_back(e);
               cnt_m[tid] = 3'd0;
            end else begin
               cnt_m[tid] = s;
            end
         end
         4'h7: begin e.data = 56'({tid, h[15:0]}); exp_q[2].push_back(e); end
         4'h6: exp_q[3].push_back(e);
         4'h4: exp_q[4].push_back(e);
         4'h3: begin e.data = h; exp_q[5].push_back(e); end
         default: n_drop++;
      endcase
   endtask

   // Holds hdrValid after acceptance so consecutive calls are back to back.
   task automatic drive_hdr(input logic [7:0] ctrl, input logic [55:0] h);
      bit ok;
      hif.hdrValid   = 1'b1;
      hif.hdrControl = ctrl;
      hif.hdrHeader  = h;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (hif.hdrReady === 1'b1) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout ctrl=%h hdrReady=%b required=1", ctrl, hif.hdrReady);
         hif.hdrValid = 1'b0;
         return;
      end
      expect_hdr(ctrl, h, cyc);
      @(posedge clock); #1;
   endtask

   task automatic idle(input int n);
      hif.hdrValid = 1'b0;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic count_sweep(input string tag);
      int n;
      n = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (hif.hdrReady === 1'b1) break;
         n++;
      end
      checks++;
      if (n != 256) begin
         errors++;
         $display("FAIL %s hdrReady low cycles=%0d required=256", tag, n);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks++;
      if ({hif.hdrReady, offloadPush, sendDonePush, ackPush, wrDonePush, rdDonePush, reqValid} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b required=0",
                  {hif.hdrReady, offloadPush, sendDonePush, ackPush, wrDonePush, rdDonePush, reqValid});
      end
      checks++;
      if (queueNumRdData !== 16'h0 || offloadData !== 8'h0 || sendDoneData !== 8'h0) begin
         errors++;
         $display("FAIL reset_data qn=%h off=%h sd=%h required=0", queueNumRdData, offloadData, sendDoneData);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      count_sweep("sweep");
      // Abort a sweep halfway; the restart must take the full depth again.
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (100) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      count_sweep("sweep_restart");
   endtask

   task automatic test_first_send();
      tot_m[8'hFF] = 3'd4;
      drive_hdr(8'h00, {8'hFF, 48'h0});
      idle(3);
   endtask

   task automatic test_back_to_back();
      tot_m[8'h12] = 3'd3;
      tot_m[8'h13] = 3'd2;
      repeat (4) drive_hdr(8'h00, {8'h12, 48'h0});
      drive_hdr(8'h00, {8'h13, 48'h0});
      drive_hdr(8'h00, {8'h12, 48'h0});
      drive_hdr(8'h00, {8'h13, 48'h0});
      drive_hdr(8'h00, {8'h12, 48'h0});
      idle(3);
   endtask

   task automatic test_ack_qn();
      drive_hdr(8'h07, {8'h05, 32'h0, 16'hBEEF});
      hif.hdrValid = 1'b0;
      queueNumRd = 1'b1;
      queueNumRdAddr = 8'h05;
      @(posedge clock); #1;
      queueNumRd = 1'b0;
      @(negedge clock);
      checks++;
      if (queueNumRdData !== 16'hBEEF) begin
         errors++;
         $display("FAIL qn_read got=%h required=beef", queueNumRdData);
      end
      @(posedge clock); #1;
      drive_hdr(8'h07, {8'h06, 32'h0, 16'h1111});
      queueNumRd = 1'b1;
      queueNumRdAddr = 8'h06;
      drive_hdr(8'h07, {8'h06, 32'h0, 16'h2222});
      hif.hdrValid = 1'b0;
      queueNumRd = 1'b0;
      @(negedge clock);
      checks++;
      if (queueNumRdData !== 16'h1111) begin
         errors++;
         $display("FAIL qn_rdw_old got=%h required=1111", queueNumRdData);
      end
      @(posedge clock); #1;
      queueNumRd = 1'b1;
      @(posedge clock); #1;
      queueNumRd = 1'b0;
      @(negedge clock);
      checks++;
      if (queueNumRdData !== 16'h2222) begin
         errors++;
         $display("FAIL qn_rdw_new got=%h required=2222", queueNumRdData);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_backpressure();
      logic [7:0] ops [5];
      ops = '{8'h00, 8'h07, 8'h06, 8'h04, 8'h03};
      tot_m[8'h20] = 3'd2;
      offloadAfull = 1'b1;
      hif.hdrValid = 1'b1;
      hif.hdrControl = 8'h00;
      hif.hdrHeader = {8'h20, 48'h0};
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checks++;
         if (hif.hdrReady !== 1'b0) begin
            errors++;
            $display("FAIL bp_offload hdrReady=%b required=0", hif.hdrReady);
         end
      end
      @(posedge clock); #1;
      offloadAfull = 1'b0;
      drive_hdr(8'h00, {8'h20, 48'h0});
      idle(2);
      for (int k = 0; k < 5; k++) begin
         sendDoneAfull = (k == 0);
         ackFull       = (k == 1);
         wrDoneFull    = (k == 2);
         rdDoneFull    = (k == 3);
         reqReady      = (k != 4);
         hif.hdrValid   = 1'b1;
         hif.hdrControl = ops[k];
         hif.hdrHeader  = {8'h21, 48'h1234};
         @(negedge clock);
         checks++;
         if (hif.hdrReady !== 1'b0) begin
            errors++;
            $display("FAIL bp_full op=%h hdrReady=%b required=0", ops[k], hif.hdrReady);
         end
         @(posedge clock); #1;
         hif.hdrValid = 1'b0;
         {sendDoneAfull, ackFull, wrDoneFull, rdDoneFull} = 4'b0;
         reqReady = 1'b1;
      end
      idle(2);
   endtask

   task automatic test_single_seg();
      tot_m[8'h30] = 3'd1;
      tot_m[8'h31] = 3'd0;
      drive_hdr(8'h00, {8'h30, 48'h0});
      drive_hdr(8'h00, {8'h30, 48'h0});
      drive_hdr(8'h00, {8'h31, 48'h0});
      idle(2);
      drive_hdr(8'h00, {8'h30, 48'h0});
      idle(3);
   endtask

   task automatic test_paths();
      logic [55:0] rq;
      rq = {8'h43, 16'($urandom), 32'($urandom)};
      drive_hdr(8'h06, {8'h41, 48'h0});
      drive_hdr(8'h04, {8'h42, 48'h0});
      drive_hdr(8'h03, rq);
      idle(2);
   endtask

   task automatic test_unknown();
      logic [7:0] uk [2];
      uk = '{8'h09, 8'h17};
      for (int i = 0; i < 2; i++) begin
         hif.hdrValid = 1'b1;
         hif.hdrControl = uk[i];
         hif.hdrHeader = {8'h05, 32'h0, 16'h7777};
         @(negedge clock);
         checks++;
         if (hif.hdrReady !== 1'b1) begin
            errors++;
            $display("FAIL unknown_ready op=%h hdrReady=%b required=1", uk[i], hif.hdrReady);
         end
         expect_hdr(uk[i], hif.hdrHeader, cyc);
         @(posedge clock); #1;
      end
      hif.hdrValid = 1'b0;
      queueNumRd = 1'b1;
      queueNumRdAddr = 8'h05;
      @(posedge clock); #1;
      queueNumRd = 1'b0;
      @(negedge clock);
      checks++;
      if (queueNumRdData !== 16'hBEEF) begin
         errors++;
         $display("FAIL unknown_no_qn_write got=%h required=beef", queueNumRdData);
      end
      @(posedge clock); #1;
`ifdef HDR_STATS_EN
      checks++;
      if (statDropCnt !== 16'(n_drop) || statSendCnt !== 16'(n_send)) begin
         errors++;
         $display("FAIL stats drop=%0d send=%0d required drop=%0d send=%0d",
                  statDropCnt, statSendCnt, n_drop, n_send);
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         cnt_m[i] = 3'd0;
         tot_m[i] = 3'd4;
      end
      hif.hdrValid = 1'b0;
      hif.hdrControl = 8'h00;
      hif.hdrHeader = '0;
      segNumRdData = 3'd0;
      {offloadAfull, sendDoneAfull, ackFull, wrDoneFull, rdDoneFull} = 5'b0;
      reqReady = 1'b1;
      queueNumRd = 1'b0;
      queueNumRdAddr = 8'h00;
      test_reset();
      test_first_send();
      test_back_to_back();
      test_ack_qn();
      test_backpressure();
      test_single_seg();
      test_paths();
      test_unknown();
      idle(5);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (exp_q[k].size() != 0) begin
            errors++;
            $display("FAIL %s missing pushes=%0d required=0", nm[k], exp_q[k].size());
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rdmap_hdr_dispatch.md
Name: rdmap_hdr_dispatch

Overview:
- Parametrised successor of the RDMAP header classifier. It sits between the DDP header output and the operator FIFOs, IRRQ and DdpHdrGen.
- Classifies each DDP header by opcode and routes it to the ack, offload-SOP, send-EOP, write-done, read-done or request path.
- Keeps two per-TID tables: a send segment counter and the last acked queue number.
- New over the previous generation:
  - valid/ready backpressure instead of silent drops;
  - read-after-write forwarding on the segment counter;
  - an EOP push;
  - a read-done path;
  - an init sweep on both tables.

Parameters:
- HDR_W, 56, DDP header width.
- TID_W, 8, TID width; each table has 2^TID_W entries.
- TID_LSB, 48, LSB of the TID field in the header.
- QN_W, 16, queue-number width.
- QN_LSB, 0, LSB of the queue-number field in the header.
- CNT_W, 3, segment-counter width.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- hdrValid  in  1  header valid
- hdrReady  out  1  header accepted when hdrValid & hdrReady
- hdrControl  in  8  opcode
- hdrHeader  in  HDR_W  header
- segNumRd  out  1  read strobe to the external segment-total table
- segNumRdAddr  out  TID_W  TID to read
- segNumRdData  in  CNT_W  segment total, valid 1 cycle after segNumRd
- offloadPush  out  1  first segment of a send
- offloadData  out  TID_W  TID of that send
- offloadAfull  in  1  offload FIFO has at most 1 free entry
- sendDonePush  out  1  last segment of a send
- sendDoneData  out  TID_W  TID of that send
- sendDoneAfull  in  1  send-done FIFO has at most 1 free entry
- ackPush  out  1  ack header
- ackData  out  TID_W+QN_W  {TID, QN}
- ackFull  in  1  ack FIFO full
- wrDonePush  out  1  write-done header
- wrDoneData  out  TID_W  TID
- wrDoneFull  in  1  write-done FIFO full
- rdDonePush  out  1  read-done header
- rdDoneData  out  TID_W  TID
- rdDoneFull  in  1  read-done FIFO full
- reqValid  out  1  request to IRRQ
- reqInfo  out  HDR_W  full header
- reqReady  in  1  IRRQ can take the request
- queueNumRd  in  1  queue-number read strobe from DdpHdrGen
- queueNumRdAddr  in  TID_W  TID to read
- queueNumRdData  out  QN_W  queue number, 1-cycle latency

Behaviour:
- Reset: all push/valid outputs are 0 and hdrReady is 0. queueNumRdData, offloadData, sendDoneData and the forward register are 0. The init counter is 0.
- Init sweep: for 2^TID_W cycles after reset deasserts, write 0 to every entry of both tables, one address per cycle. hdrReady stays 0 for the whole sweep.
- Reset asserted mid-operation or mid-sweep aborts everything; the sweep restarts from address 0.
- Opcode decode uses hdrControl[3:0] and requires hdrControl[7:4]==0:
  - SEND = 0000
  - REQ = 0011
  - ACK = 0111
  - WR_DONE = 0110
  - RD_DONE = 0100
  - any other value is unknown.
- hdrReady (combinational, only after init), per opcode:
  - SEND: ~offloadAfull & ~sendDoneAfull
  - ACK: ~ackFull
  - WR_DONE: ~wrDoneFull
  - RD_DONE: ~rdDoneFull
  - REQ: reqReady
  - unknown: 1; the header is consumed and discarded.
- Ack, write-done, read-done and request paths are combinational on the accept cycle (0 latency).
- An accepted ACK also writes QN into the queue-number table at its TID.
- Queue-number read-during-write to the same address returns the old value.
- Send pipeline:
  - Cycle 0 (accept): assert segNumRd with the TID; read the counter table at the TID.
  - Cycle 1: cnt = fwdHit ? fwdData : tableData. sent = cnt+1, truncated to CNT_W bits.
  - SOP when sent==1: offloadPush=1.
  - EOP when sent==segNumRdData, or segNumRdData==0, or sent==0 (wrap): sendDonePush=1, and write 0 back to the table.
  - Otherwise write sent back to the table.
  - SOP and EOP can both assert in the same cycle.
- Forwarding: if a send accepted in cycle N has the same TID as the cycle-1 write in cycle N, set fwdHit and use the written value in cycle N+1. Back-to-back same-TID sends sustain 1 header/cycle.
- The Afull thresholds guarantee that the cycle-1 pushes never overflow.

Optional Feature:
- HDR_STATS_EN defined adds outputs statSendCnt[15:0] and statDropCnt[15:0].
  - statSendCnt counts accepted SENDs; statDropCnt counts accepted unknown opcodes.
  - Both counters saturate at 16'hFFFF and clear on reset.
- HDR_STATS_EN undefined: the counters and their ports do not exist.

Decomposition:
- Package rdmap_hdr_pkg: opcode constants; default widths and field LSBs; typedef for the class enum {CLS_SEND, CLS_REQ, CLS_ACK, CLS_WRDONE, CLS_RDDONE, CLS_UNKNOWN}.
- Sub-module rdmap_tid_table(DEPTH_W, DATA_W): 1R1W synchronous table with built-in init sweep and an initDone output. Instantiated twice.

Test Plan:
- Reset release with TID_W=8 -> hdrReady=0 for 256 cycles, then hdrReady=1; a SEND to TID 0xFF yields offloadPush on its first packet.
- Three back-to-back SENDs to TID 0x12 with segNumRdData=3 -> offload at cycle 1 of send 1 with data 0x12; sendDone at cycle 1 of send 3; a fourth SEND is a SOP again.
- ACK with TID 0x05, QN 0xBEEF, then queueNumRd to 0x05 -> ackPush with data 0x05BEEF; queueNumRdData=0xBEEF one cycle after the read.
- SEND with offloadAfull=1 -> hdrReady=0 and nothing pushed; drop offloadAfull -> header accepted exactly once.
- segNumRdData=1 -> offloadPush and sendDonePush in the same cycle; entry rewritten to 0.
- hdrControl=0x09, then 0x17 -> both consumed, no pushes; statDropCnt=2 when HDR_STATS_EN is defined.
